// File: rtl/rs_pkg.sv
// Shared constants for the GF(2^8) arithmetic blocks: field polynomial,
// result FIFO depth, default widths, and a combinational GF multiply helper.
package rs_pkg;

   localparam int         RS_M          = 8;
   localparam int         RS_N_REQ      = 4;
   localparam int         RS_TAG_W      = 4;
   localparam int         RS_FIFO_DEPTH = 2;
   localparam logic [8:0] RS_GF_POLY    = 9'h11D;

   // Shift-and-add GF(2^8) multiply, reducing by the field polynomial after each shift
   function automatic logic [RS_M-1:0] gf_mul(input logic [RS_M-1:0] a,
                                              input logic [RS_M-1:0] b);
      logic [RS_M-1:0] acc;
      logic [RS_M-1:0] x;
      acc = '0;
      x   = a;
      for (int i = 0; i < RS_M; i++) begin
         if (b[i]) acc = acc ^ x;
         x = x[RS_M-1] ? ({x[RS_M-2:0], 1'b0} ^ RS_GF_POLY[RS_M-1:0])
                       : {x[RS_M-2:0], 1'b0};
      end
      return acc;
   endfunction

endpackage

// File: rtl/gf_mul_clk.sv
// Registered GF(2^8) multiplier: product appears one cycle after the operands.
// The output register is deliberately unreset; consumers qualify it with their
// own valid bit.
module gf_mul_clk
   import rs_pkg::*;
(
   input  logic            clk_in,
   input  logic [RS_M-1:0] a,
   input  logic [RS_M-1:0] b,
   output logic [RS_M-1:0] prod
);

   // Stage 1: register the field product
   always_ff @(posedge clk_in) begin
      prod <= gf_mul(a, b);
   end

endmodule

// File: rtl/gf_mul_arbiter.sv
// Round-robin arbiter sharing one registered GF(2^8) multiplier among N_REQ
// requesters. Grants are credit-limited so the 2-entry result FIFO can never
// overflow; results leave in grant order through a valid/ready port.
module gf_mul_arbiter
   import rs_pkg::*;
#(
   parameter int N_REQ = RS_N_REQ,
   parameter int m     = RS_M,
   parameter int TAG_W = RS_TAG_W,
   localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
)(
   input  logic                 clk_in,
   input  logic                 rst_n,
   input  logic [N_REQ-1:0]     req_valid,
   output logic [N_REQ-1:0]     req_ready,
   input  logic [N_REQ*m-1:0]   req_a,
   input  logic [N_REQ*m-1:0]   req_b,
   input  logic [N_REQ*TAG_W-1:0] req_tag,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [ID_W-1:0]      rsp_id,
   output logic [TAG_W-1:0]     rsp_tag,
   output logic [m-1:0]         rsp_prod,
   output logic                 busy
);

   localparam int PTR_W = (RS_FIFO_DEPTH > 1) ? $clog2(RS_FIFO_DEPTH) : 1;

   logic [ID_W-1:0]  ptr;
   logic             grant_found;
   logic [ID_W-1:0]  grant_id;
   logic             credit;
   logic             hs;
   logic             push;
   logic             pop;
   logic [2:0]       occ;
   logic [m-1:0]     a_sel;
   logic [m-1:0]     b_sel;
   logic [TAG_W-1:0] tag_sel;

   logic             s1_vld;
   logic [ID_W-1:0]  s1_id;
   logic [TAG_W-1:0] s1_tag;
   logic [m-1:0]     s1_prod;

   logic [ID_W-1:0]  id_mem   [RS_FIFO_DEPTH];
   logic [TAG_W-1:0] tag_mem  [RS_FIFO_DEPTH];
   logic [m-1:0]     prod_mem [RS_FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [1:0]       count;

   // Round-robin search starting at ptr; first valid requester wins
   always_comb begin
      int idx;
      idx         = 0;
      grant_found = 1'b0;
      grant_id    = '0;
      for (int k = 0; k < N_REQ; k++) begin
         idx = int'(ptr) + k;
         if (idx >= N_REQ) idx = idx - N_REQ;
         if (!grant_found && req_valid[idx]) begin
            grant_found = 1'b1;
            grant_id    = ID_W'(idx);
         end
      end
   end

   // Credit counts entries that will still occupy the FIFO after this cycle's pop,
   // including the product currently in the multiplier stage.
   assign pop    = rsp_valid && rsp_ready;
   assign push   = s1_vld;
   assign occ    = {1'b0, count} - {2'b00, pop} + {2'b00, s1_vld};
   assign credit = (occ < 3'd2);
   assign hs     = rst_n && grant_found && credit;

   // One-hot ready to the winner only, forced low while in reset
   always_comb begin
      req_ready = '0;
      if (hs) req_ready[grant_id] = 1'b1;
   end

   assign a_sel   = req_a[grant_id*m +: m];
   assign b_sel   = req_b[grant_id*m +: m];
   assign tag_sel = req_tag[grant_id*TAG_W +: TAG_W];

   gf_mul_clk u_mul (
      .clk_in (clk_in),
      .a      (a_sel),
      .b      (b_sel),
      .prod   (s1_prod)
   );

   // Stage 1: valid and round-robin pointer (control, reset)
   always_ff @(posedge clk_in) begin
      if (!rst_n) begin
         s1_vld <= 1'b0;
         ptr    <= '0;
      end else begin
         s1_vld <= hs;
         if (hs) begin
            if (int'(grant_id) == N_REQ - 1) ptr <= '0;
            else                             ptr <= grant_id + 1'b1;
         end
      end
   end

   // Stage 1: metadata travelling beside the multiplier product
   always_ff @(posedge clk_in) begin
      if (hs) begin
         s1_id  <= grant_id;
         s1_tag <= tag_sel;
      end
   end

   // Stage 2: FIFO occupancy and pointers (control, reset)
   always_ff @(posedge clk_in) begin
      if (!rst_n) begin
         count  <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

   // Stage 2: FIFO storage written from the multiplier stage
   always_ff @(posedge clk_in) begin
      if (push) begin
         id_mem[wr_ptr]   <= s1_id;
         tag_mem[wr_ptr]  <= s1_tag;
         prod_mem[wr_ptr] <= s1_prod;
      end
   end

   // Head is zeroed when empty so unreset storage never shows on the port
   assign rsp_valid = (count != 2'd0);
   assign rsp_id    = rsp_valid ? id_mem[rd_ptr]   : '0;
   assign rsp_tag   = rsp_valid ? tag_mem[rd_ptr]  : '0;
   assign rsp_prod  = rsp_valid ? prod_mem[rd_ptr] : '0;
   assign busy      = s1_vld || rsp_valid;

   fifo_no_overflow: assert property (@(posedge clk_in) disable iff (!rst_n)
      !(push && !pop && count == 2'(RS_FIFO_DEPTH)));

endmodule

// File: tb/tb_gf_mul_arbiter.sv
// Self-checking bench for gf_mul_arbiter: randomized requests and backpressure
// compared every cycle against a queue-based reference model, plus directed
// literal scenarios.
module tb_gf_mul_arbiter;

   localparam int N  = 4;
   localparam int M  = 8;
   localparam int TW = 4;

   logic            clk_in;
   logic            rst_n;
   logic [N-1:0]    req_valid;
   logic [N-1:0]    req_ready;
   logic [N*M-1:0]  req_a;
   logic [N*M-1:0]  req_b;
   logic [N*TW-1:0] req_tag;
   logic            rsp_valid;
   logic            rsp_ready;
   logic [1:0]      rsp_id;
   logic [TW-1:0]   rsp_tag;
   logic [M-1:0]    rsp_prod;
   logic            busy;

   gf_mul_arbiter #(.N_REQ(N), .m(M), .TAG_W(TW)) dut (
      .clk_in    (clk_in),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_tag   (req_tag),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_tag   (rsp_tag),
      .rsp_prod  (rsp_prod),
      .busy      (busy)
   );

   initial clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // GF(2^8) reference via log/antilog tables over generator 0x02
   logic [7:0] gexp [255];
   int         glog [256];

   function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
      if (a == 8'h00 || b == 8'h00) return 8'h00;
      return gexp[(glog[a] + glog[b]) % 255];
   endfunction

   // Reference model: every granted request in grant order, aged per cycle.
   // age 0 = in the multiplier stage, age >= 1 = visible in the result buffer.
   typedef struct {
      logic [1:0]    id;
      logic [TW-1:0] tag;
      logic [7:0]    prod;
      int            age;
   } ent_t;
   ent_t mq[$];
   int   m_ptr = 0;

   typedef struct {
      logic [1:0] id;
      logic [7:0] prod;
   } lg_t;
   lg_t lg[$];

   int         n_buf, n_fly, winner, idx;
   logic       e_valid, e_pop, e_credit, after_rst;
   logic [3:0] e_ready;
   ent_t       ne;

   // Compare process: derive expectations from the model, check, then advance the model
   always @(negedge clk_in) begin
      cyc++;
      if (!rst_n) begin
         chk("rst_req_ready", 32'(req_ready), 32'h0);
         mq.delete();
         m_ptr     = 0;
         after_rst = 1'b1;
      end else begin
         n_buf = 0;
         n_fly = 0;
         foreach (mq[i]) begin
            if (mq[i].age >= 1) n_buf++;
            else                n_fly++;
         end
         e_valid  = (mq.size() > 0) && (mq[0].age >= 1);
         e_pop    = e_valid && rsp_ready;
         e_credit = ((n_buf - (e_pop ? 1 : 0) + n_fly) < 2);
         winner   = -1;
         for (int k = 0; k < N; k++) begin
            idx = (m_ptr + k) % N;
            if (winner < 0 && req_valid[idx]) winner = idx;
         end
         e_ready = (e_credit && winner >= 0) ? (4'b0001 << winner) : 4'b0000;

         chk("req_ready", 32'(req_ready), 32'(e_ready));
         chk("rsp_valid", 32'(rsp_valid), 32'(e_valid));
         chk("busy", 32'(busy), 32'(mq.size() > 0));
         if (e_valid) begin
            chk("rsp_id", 32'(rsp_id), 32'(mq[0].id));
            chk("rsp_tag", 32'(rsp_tag), 32'(mq[0].tag));
            chk("rsp_prod", 32'(rsp_prod), 32'(mq[0].prod));
         end
         if (after_rst) begin
            chk("rst_rsp_fields", {18'd0, rsp_id, rsp_tag, rsp_prod}, 32'h0);
            after_rst = 1'b0;
         end

         if (rsp_valid && rsp_ready) begin
            lg.push_back('{id: rsp_id, prod: rsp_prod});
         end
         if (e_pop) void'(mq.pop_front());
         foreach (mq[i]) mq[i].age++;
         if (e_ready != 4'b0000) begin
            ne.id   = 2'(winner);
            ne.tag  = req_tag[winner*TW +: TW];
            ne.prod = ref_mul(req_a[winner*M +: M], req_b[winner*M +: M]);
            ne.age  = 0;
            mq.push_back(ne);
            m_ptr = (winner + 1) % N;
         end
      end
   end

   // Random driver: refresh a requester after acceptance; optional random backpressure
   int         mode      = 0;
   logic       rnd_ready = 1'b0;
   logic [3:0] acc;

   function automatic logic [7:0] pick();
      int r;
      r = $urandom_range(0, 9);
      if (r == 0) return 8'h00;
      if (r == 1) return 8'h01;
      return 8'($urandom_range(0, 255));
   endfunction

   always begin
      @(negedge clk_in);
      acc = req_valid & req_ready;
      @(posedge clk_in);
      #2;
      if (mode == 2) begin
         for (int i = 0; i < N; i++) begin
            if (acc[i] || !req_valid[i]) begin
               req_valid[i]        = ($urandom_range(0, 2) != 0);
               req_a[i*M +: M]     = pick();
               req_b[i*M +: M]     = pick();
               req_tag[i*TW +: TW] = 4'($urandom_range(0, 15));
            end
         end
      end
      if (rnd_ready) rsp_ready = ($urandom_range(0, 3) != 0);
   end

   task automatic cycles(input int n);
      repeat (n) @(posedge clk_in);
      #1;
   endtask

   logic [7:0] x;

   initial begin
      x = 8'h01;
      for (int i = 0; i < 255; i++) begin
         gexp[i] = x;
         glog[x] = i;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1D : 8'h00);
      end

      rst_n     = 1'b0;
      req_valid = '0;
      req_a     = '0;
      req_b     = '0;
      req_tag   = '0;
      rsp_ready = 1'b1;

      // Pin the reference multiplier to hand-computed products
      chk("pin_02x80", 32'(ref_mul(8'h02, 8'h80)), 32'h1D);
      chk("pin_80x80", 32'(ref_mul(8'h80, 8'h80)), 32'h13);
      chk("pin_03x03", 32'(ref_mul(8'h03, 8'h03)), 32'h05);
      chk("pin_01xB7", 32'(ref_mul(8'h01, 8'hB7)), 32'hB7);
      chk("pin_00x5A", 32'(ref_mul(8'h00, 8'h5A)), 32'h00);
      chk("pin_5Ax00", 32'(ref_mul(8'h5A, 8'h00)), 32'h00);

      cycles(3);
      rst_n = 1'b1;
      cycles(2);

      // Single request: product visible two cycles after the handshake
      req_valid     = 4'b0001;
      req_a[7:0]    = 8'h02;
      req_b[7:0]    = 8'h80;
      req_tag[3:0]  = 4'h5;
      @(negedge clk_in);
      chk("single_ready", 32'(req_ready), 32'h1);
      cycles(1);
      req_valid = 4'b0000;
      @(negedge clk_in);
      chk("single_early", 32'(rsp_valid), 32'h0);
      cycles(1);
      @(negedge clk_in);
      chk("single_valid", 32'(rsp_valid), 32'h1);
      chk("single_id", 32'(rsp_id), 32'h0);
      chk("single_tag", 32'(rsp_tag), 32'h5);
      chk("single_prod", 32'(rsp_prod), 32'h1D);
      cycles(3);

      // All four valid with fixed operands after a reset (pointer back at 0)
      rst_n = 1'b0;
      cycles(1);
      rst_n = 1'b1;
      lg.delete();
      req_a     = {8'h01, 8'h00, 8'h03, 8'h80};
      req_b     = {8'hB7, 8'h5A, 8'h03, 8'h80};
      req_tag   = {4'h3, 4'h2, 4'h1, 4'h0};
      req_valid = 4'b1111;
      cycles(12);
      if (lg.size() < 8) begin
         chk("rr_log_len", 32'(lg.size()), 32'd8);
      end else begin
         for (int i = 0; i < 8; i++) chk("rr_order", 32'(lg[i].id), 32'(i % 4));
         chk("rr_prod0", 32'(lg[0].prod), 32'h13);
         chk("rr_prod1", 32'(lg[1].prod), 32'h05);
         chk("rr_prod2", 32'(lg[2].prod), 32'h00);
         chk("rr_prod3", 32'(lg[3].prod), 32'hB7);
      end

      // Backpressure: buffer fills to two, grants stop, head holds
      rsp_ready = 1'b0;
      cycles(5);
      @(negedge clk_in);
      chk("bp_ready", 32'(req_ready), 32'h0);
      chk("bp_valid", 32'(rsp_valid), 32'h1);
      chk("bp_busy", 32'(busy), 32'h1);
      rsp_ready = 1'b1;
      cycles(6);

      // Randomized traffic with random backpressure
      mode      = 2;
      rnd_ready = 1'b1;
      cycles(300);

      // Reset in the middle of traffic
      rst_n = 1'b0;
      cycles(1);
      rst_n = 1'b1;
      @(negedge clk_in);
      chk("midrst_valid", 32'(rsp_valid), 32'h0);
      chk("midrst_busy", 32'(busy), 32'h0);
      cycles(300);

      // Drain and go idle
      mode      = 0;
      rnd_ready = 1'b0;
      cycles(1);
      req_valid = '0;
      rsp_ready = 1'b1;
      cycles(10);
      @(negedge clk_in);
      chk("drain_idle", 32'(busy), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/gf_mul_arbiter.md
GF_MUL_ARBITER -- requirements
Module: gf_mul_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4: number of requesters sharing one GF(2^8) multiplier.
REQ-002 SHALL have parameter m, default 8: symbol width.
REQ-003 SHALL have parameter TAG_W, default 4: per-request tag width.
REQ-004 SHALL have port clk_in, input, 1: single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n, input, 1: synchronous active-low reset.
REQ-006 SHALL have port req_valid, input, N_REQ: per-requester operand valid.
REQ-007 SHALL have port req_ready, output, N_REQ: per-requester accept.
REQ-008 SHALL have port req_a, input, N_REQ*m: multiplicand of requester i in bits [i*m +: m].
REQ-009 SHALL have port req_b, input, N_REQ*m: multiplier operand, packed like req_a.
REQ-010 SHALL have port req_tag, input, N_REQ*TAG_W: opaque tag, packed per requester.
REQ-011 SHALL have port rsp_valid, output, 1: result available.
REQ-012 SHALL have port rsp_ready, input, 1: downstream accepts the result.
REQ-013 SHALL have port rsp_id, output, clog2(N_REQ): index of the originating requester.
REQ-014 SHALL have port rsp_tag, output, TAG_W: tag echoed from the request.
REQ-015 SHALL have port rsp_prod, output, m: product req_a·req_b in GF(2^8), polynomial x^8+x^4+x^3+x^2+1 (0x11D).
REQ-016 SHALL have port busy, output, 1: high when a multiply is in flight or the result FIFO is non-empty.

Function
REQ-017 SHALL accept a request only when req_valid[i] && req_ready[i] (handshake); at most one handshake per cycle.
REQ-018 SHALL drive at most one req_ready bit high, to the round-robin winner among valid requesters, and only when credit is available (REQ-021); req_ready may depend combinationally on req_valid.
REQ-019 SHALL give highest priority to requester ptr; after a handshake with requester g, ptr SHALL become (g+1) mod N_REQ; with no handshake, ptr SHALL stay unchanged.
REQ-020 SHALL present the granted operands to the multiplier in the handshake cycle; the product appears one cycle later. Metadata (s1_vld, id, tag) SHALL be registered alongside.
REQ-021 SHALL hold results in a 2-entry result FIFO; credit is available when (count − pop_this_cycle) + s1_vld < 2, giving one result per cycle sustained while rsp_ready=1.
REQ-022 SHALL push {id, tag, prod} into the FIFO on the edge after the handshake; rsp_valid SHALL rise after that edge (handshake edge to rsp_valid = 2 cycles minimum).
REQ-023 SHALL present the FIFO head on rsp_*; on rsp_valid && rsp_ready, the head SHALL pop.
REQ-024 SHALL hold rsp_* stable while rsp_valid && !rsp_ready.
REQ-025 SHALL allow a simultaneous push and pop when the FIFO is full, leaving count unchanged.
REQ-026 SHALL never overflow the FIFO; a push when count=2 without a pop is a design error, checked by assertion.
REQ-027 SHALL return results in grant order, with no reordering and no loss.

Reset
REQ-028 SHALL, while rst_n=0 at an edge, clear ptr=0, s1_vld=0, FIFO count and pointers=0, rsp_id=0, rsp_tag=0, rsp_prod=0, busy=0, and force req_ready=0.
REQ-029 SHALL, on reset mid-operation, discard in-flight and buffered results; the multiplier's unreset output SHALL be ignored because s1_vld=0.

Structure
REQ-030 SHALL place the GF polynomial constant 0x11D, the FIFO depth 2, and the default widths in shared package rs_pkg.
REQ-031 SHALL instantiate exactly one sub-module, gf_mul_clk (the registered GF(2^8) multiplier with 1-cycle latency); all requesters share that one instance.

Verification
REQ-032 SHALL verify single request: req0 a=0x02, b=0x80, tag=0x5, rsp_ready=1 -> 2 cycles later rsp_valid=1, rsp_id=0, rsp_tag=0x5, rsp_prod=0x1D.
REQ-033 SHALL verify all four requesters valid continuously with rsp_ready=1 -> grants 0,1,2,3,0,… one per cycle; products include 0x80·0x80=0x13 and 0x03·0x03=0x05.
REQ-034 SHALL verify backpressure: rsp_ready=0 for 5 cycles with all requesters valid -> exactly 2 results buffered, req_ready=0, rsp_* stable; on release, results drain in order with none lost.
REQ-035 SHALL verify full with simultaneous pop: count=2, s1_vld=0, rsp_ready=1 -> a grant issues in the same cycle and count never exceeds 2.
REQ-036 SHALL verify reset mid-operation: rst_n=0 for 1 cycle with 1 in flight and 2 buffered -> rsp_valid=0, busy=0, ptr=0, and no stale response appears afterwards.
REQ-037 SHALL verify identities: a=0x00 or b=0x00 -> product 0x00; a=0x01, b=0xB7 -> product 0xB7.
